// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake bundle for uart_tx_arbiter.
// Byte i of req_data sits at [8i+7:8i].
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one 8N1 UART transmitter.
// Define UART_TX_ARB_PARITY_EN to add an even parity bit (8E1).
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  localparam int DIVISOR  = CLK_FREQ / BAUD_RATE,
  localparam int IDW      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  uart_tx_arbiter_if.slave req,
  output logic            STX,
  output logic            busy,
  output logic [IDW-1:0]  grant_id
);

  localparam int BW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

  generate
    if (DIVISOR < 2) begin : g_div_chk
      $error("uart_tx_arbiter: DIVISOR must be >= 2");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_req_chk
      $error("uart_tx_arbiter: NUM_REQ must be 2..16");
    end
  endgenerate

`ifdef UART_TX_ARB_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t         state_q, state_d;
  logic           stx_q, stx_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic [2:0]     bitc_q, bitc_d;
  logic [7:0]     sh_q, sh_d;
  logic           par_q, par_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] win;
  logic           any;
  logic           last;
  int             j;

  // Cyclic scan starting just after the last winner.
  always_comb begin
    win = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req.req_valid[j]) begin
        any = 1'b1;
        win = IDW'(j);
      end
    end
  end

  always_comb begin
    req.req_ready = '0;
    if (PRESETn && state_q == IDLE && any)
      req.req_ready[win] = 1'b1;
  end

  assign last = (bcnt_q == BW'(DIVISOR - 1));

  always_comb begin
    state_d = state_q;
    stx_d   = stx_q;
    bcnt_d  = bcnt_q + BW'(1);
    bitc_d  = bitc_q;
    sh_d    = sh_q;
    par_d   = par_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        stx_d  = 1'b1;
        bcnt_d = '0;
        if (any) begin
          state_d = START;
          stx_d   = 1'b0;
          sh_d    = req.req_data[8*win +: 8];
          par_d   = ^req.req_data[8*win +: 8];
          gid_d   = win;
          ptr_d   = win;
          bitc_d  = '0;
        end
      end
      START: begin
        if (last) begin
          state_d = DATA;
          stx_d   = sh_q[0];
          bcnt_d  = '0;
        end
      end
      DATA: begin
        if (last) begin
          bcnt_d = '0;
          if (bitc_q == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
            state_d = PARITY;
            stx_d   = par_q;
`else
            state_d = STOP;
            stx_d   = 1'b1;
`endif
          end else begin
            bitc_d = bitc_q + 3'd1;
            sh_d   = {1'b0, sh_q[7:1]};
            stx_d  = sh_q[1];
          end
        end
      end
`ifdef UART_TX_ARB_PARITY_EN
      PARITY: begin
        if (last) begin
          state_d = STOP;
          stx_d   = 1'b1;
          bcnt_d  = '0;
        end
      end
`endif
      STOP: begin
        if (last) begin
          state_d = IDLE;
          bcnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        stx_d   = 1'b1;
        bcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      stx_q   <= 1'b1;
      bcnt_q  <= '0;
      bitc_q  <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      gid_q   <= '0;
      ptr_q   <= IDW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      stx_q   <= stx_d;
      bcnt_q  <= bcnt_d;
      bitc_q  <= bitc_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign STX      = stx_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = gid_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin transmit controller that shares one UART serial output line among several byte-producing requesters. It accepts one byte per frame through a valid/ready handshake, then serializes it as an 8N1 frame (start, 8 data bits LSB first, optional parity, stop) at a fixed baud rate derived from the clock. It sits between APB-side UART channel logic and the serial pin, driving the same line a tty model samples.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `CLK_FREQ`, default 50000000: PCLK frequency in Hz.
- `BAUD_RATE`, default 115200: serial bit rate.
- `DIVISOR` (localparam) = CLK_FREQ/BAUD_RATE, truncated. Must be >= 2; otherwise elaboration error via $error.
- `IDW` (localparam) = max(1, $clog2(NUM_REQ)).

Ports:
- `PCLK`  in  1  the only clock; all logic on rising edge.
- `PRESETn`  in  1  reset, synchronous and active-low.
- `req_valid`  in  NUM_REQ  per-requester byte available.
- `req_data`  in  8*NUM_REQ  byte i at [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot accept strobe; transfer = valid&ready same cycle.
- `STX`  out  1  serial output, idle high, registered.
- `busy`  out  1  high while a frame is in progress (state != IDLE).
- `grant_id`  out  IDW  index of most recently accepted requester.

## Operation
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: STX=1. If any req_valid, the winner is the first valid index scanning cyclically from ptr+1. req_ready is combinational and asserts only for the winner, only in IDLE. On that edge: latch byte into shift register, grant_id<=winner, ptr<=winner, STX<=0, bit counter<=0, baud counter<=0, go to START.
- START: hold STX=0 for DIVISOR cycles, then STX<=data[0], go to DATA.
- DATA: each bit held DIVISOR cycles, LSB first. After bit 7: go to PARITY (macro) or STOP with STX<=1.
- PARITY: STX=even parity (XOR of the 8 data bits) for DIVISOR cycles, then STX<=1, go to STOP.
- STOP: STX=1 for DIVISOR cycles, then go to IDLE. IDLE lasts at least one cycle, so the minimum gap is DIVISOR+1 high cycles.
- Requester rules: once asserted, valid stays high and data stays stable until ready. Arbitration is evaluated only in IDLE. Valid changes during a frame do not affect that frame.
- Baud counter is 0..DIVISOR-1 and wraps on bit boundaries. Bit counter is 3 bits.

## Timing
Reset values, applied on a PCLK edge with PRESETn=0, including mid-frame:
- STX=1, busy=0, grant_id=0, state=IDLE, ptr=NUM_REQ-1 (requester 0 has first priority), req_ready=0.
- A frame in progress is abandoned; no partial-frame completion.

Timing relative to the accept edge (cycle 0):
- STX low from cycle 0 through cycle DIVISOR-1.
- Data bit k occupies cycles DIVISOR*(k+1) through DIVISOR*(k+2)-1.
- Without the macro, STOP ends at cycle 10*DIVISOR-1 and IDLE is at cycle 10*DIVISOR. With the macro, IDLE is at cycle 11*DIVISOR.
- busy rises in the cycle after the accept edge and falls when IDLE is entered.
- Earliest next accept is at the IDLE cycle. req_ready is never high while busy.

## Configuration
- `UART_TX_ARB_PARITY_EN` defined: PARITY state is compiled in and the frame is 11 bits (8E1).
- Undefined: no PARITY state and the frame is 10 bits (8N1). Arbitration and handshake are identical in both cases.

## Test plan
Bench uses CLK_FREQ=1000000, BAUD_RATE=100000 (DIVISOR=10), NUM_REQ=4.
- Req1 valid with 0x55 after reset -> req_ready=4'b0010 for one cycle. STX 0 for 10 cycles, then 1,0,1,0,1,0,1,0 for 10 cycles each, then stop 1. busy falls 100 cycles after accept. grant_id=1.
- All four valid continuously -> accept order 0,1,2,3,0. Accepts are 101 cycles apart.
- Req2 valid continuously, req0 raises valid during req2's frame -> next accept is req0, then req2.
- PRESETn low at cycle 35 of a frame -> next edge STX=1, busy=0, grant_id=0. Following accept goes to the lowest valid index.
- With UART_TX_ARB_PARITY_EN, byte 0x07 -> cycles 90-99 STX=1 (parity), stop at 100-109, IDLE at 110. Without the macro, IDLE is at 100.
- Single requester sending 0x00 then 0xFF back-to-back -> exactly 11 consecutive high cycles between the last data bit of 0x00 and the start bit of 0xFF.
